// File: rtl/set_pkg.sv
// -----------------------------------------------------------------------------
// set_pkg
// Shared definitions for the SET host slice: field widths and offsets of the
// packed central/radius words, the mode encodings and the host FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package set_pkg;

  localparam int COORD_W   = 4;
  localparam int CENTRAL_W = 6 * COORD_W;   // {x0,y0,x1,y1,x2,y2}
  localparam int RADIUS_W  = 3 * COORD_W;   // {r0,r1,r2}
  localparam int MODE_W    = 2;
  localparam int CAND_W    = 8;

  // LSB position of each nibble inside central / radius.
  localparam int X0_LSB = 20;
  localparam int Y0_LSB = 16;
  localparam int X1_LSB = 12;
  localparam int Y1_LSB = 8;
  localparam int X2_LSB = 4;
  localparam int Y2_LSB = 0;
  localparam int R0_LSB = 8;
  localparam int R1_LSB = 4;
  localparam int R2_LSB = 0;

  localparam logic [MODE_W-1:0] MODE_SINGLE = 2'd0;
  localparam logic [MODE_W-1:0] MODE_AND    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_XOR    = 2'd2;
  localparam logic [MODE_W-1:0] MODE_TWO    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/set_host_if.sv
// -----------------------------------------------------------------------------
// set_host_if
// Requester-facing channels of the SET host: the command channel (valid/ready
// with central/radius/mode/tag) and the result channel (valid/ready with
// candidate/tag/timeout flag).
//   master : the sequencer side (drives commands, accepts results)
//   slave  : the host side (accepts commands, drives results)
// -----------------------------------------------------------------------------
interface set_host_if #(
  parameter int TAG_W = 4
);
  import set_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CENTRAL_W-1:0] cmd_central;
  logic [RADIUS_W-1:0]  cmd_radius;
  logic [MODE_W-1:0]    cmd_mode;
  logic [TAG_W-1:0]     cmd_tag;

  logic                 res_valid;
  logic                 res_ready;
  logic [CAND_W-1:0]    res_candidate;
  logic [TAG_W-1:0]     res_tag;
  logic                 res_timeout;

  modport master (
    output cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag, res_ready,
    input  cmd_ready, res_valid, res_candidate, res_tag, res_timeout
  );

  modport slave (
    input  cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag, res_ready,
    output cmd_ready, res_valid, res_candidate, res_tag, res_timeout
  );

endinterface

// File: rtl/set_cmd_fifo.sv
// -----------------------------------------------------------------------------
// set_cmd_fifo
// Synchronous DEPTH x WIDTH command FIFO with an occupancy count.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write one entry (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   rdata      : current head entry (valid when !empty)
//   level      : number of stored entries, 0..DEPTH
//   full/empty : level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module set_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and level define what is valid,
  // so resetting the array would just cost reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;  // idle, or push+pop leaves the level unchanged
      endcase
    end
  end

endmodule

// File: rtl/set_host.sv
// -----------------------------------------------------------------------------
// set_host
// Initiator side of the SET candidate-counting engine. Buffers commands in a
// FIFO, issues one at a time as a single-cycle en pulse, waits for the
// engine's valid strobe (or a watchdog timeout) and returns a tagged result.
//   clk, rst            : clock, asynchronous active-high reset
//   hif (slave)         : command channel in, result channel out
//   en                  : one-cycle start pulse to SET
//   central/radius/mode : operands to SET, valid on en and held during WAIT
//   busy                : SET is working; no new issue while high
//   valid/candidate     : SET result strobe and count
//   fifo_level          : commands currently queued
// -----------------------------------------------------------------------------
module set_host
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  set_host_if.slave              hif,
  output logic                   en,
  output logic [CENTRAL_W-1:0]   central,
  output logic [RADIUS_W-1:0]    radius,
  output logic [MODE_W-1:0]      mode,
  input  logic                   busy,
  input  logic                   valid,
  input  logic [CAND_W-1:0]      candidate,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CMD_W = CENTRAL_W + RADIUS_W + MODE_W + TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CMD_W-1:0]  push_data;
  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  state_e            state_q;
  state_e            state_d;
  logic [TAG_W-1:0]  iss_tag;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              timeout_hit;

  logic              res_valid_q;
  logic [CAND_W-1:0] res_candidate_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              res_timeout_q;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign hif.cmd_ready = ~fifo_full;
  assign push          = hif.cmd_valid & ~fifo_full;
  assign push_data     = {hif.cmd_central, hif.cmd_radius, hif.cmd_mode, hif.cmd_tag};

  set_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign en          = (state_q == ST_ISSUE);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (valid || timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (hif.res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      central         <= '0;
      radius          <= '0;
      mode            <= '0;
      iss_tag         <= '0;
      tmo_cnt         <= '0;
      res_valid_q     <= 1'b0;
      res_candidate_q <= '0;
      res_tag_q       <= '0;
      res_timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands are loaded on pop and stay put through ISSUE and WAIT.
      if (pop) {central, radius, mode, iss_tag} <= head;
      unique case (state_q)
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A real result beats a timeout landing on the same cycle.
          if (valid) begin
            res_valid_q     <= 1'b1;
            res_candidate_q <= candidate;
            res_tag_q       <= iss_tag;
            res_timeout_q   <= 1'b0;
          end else if (timeout_hit) begin
            res_valid_q     <= 1'b1;
            res_candidate_q <= '0;
            res_tag_q       <= iss_tag;
            res_timeout_q   <= 1'b1;
          end
        end
        ST_RESP: if (hif.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign hif.res_valid     = res_valid_q;
  assign hif.res_candidate = res_candidate_q;
  assign hif.res_tag       = res_tag_q;
  assign hif.res_timeout   = res_timeout_q;

endmodule

// File: tb/tb_set_host.sv
// -----------------------------------------------------------------------------
// tb_set_host
// Directed bench for set_host with a behavioural SET engine model. The model
// answers each en after a programmable latency (or never), and logs every
// accepted result. Inputs change on the falling edge; outputs are read there.
// -----------------------------------------------------------------------------
module tb_set_host;
  import set_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   en;
  logic [CENTRAL_W-1:0]   central;
  logic [RADIUS_W-1:0]    radius;
  logic [MODE_W-1:0]      mode;
  logic                   busy;
  logic                   valid;
  logic [CAND_W-1:0]      candidate;
  logic [$clog2(DEPTH):0] fifo_level;

  set_host_if #(.TAG_W(TAG_W)) hif ();

  set_host #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hif        (hif),
    .en         (en),
    .central    (central),
    .radius     (radius),
    .mode       (mode),
    .busy       (busy),
    .valid      (valid),
    .candidate  (candidate),
    .fifo_level (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // SET engine model (settings are latched at each en)
  // ---------------------------------------------------------------------------
  int          model_lat  = 66;
  bit          model_sup  = 1'b0;   // 1: never raise valid, just drop busy
  bit          model_echo = 1'b0;   // 1: candidate = central[7:0]
  logic [7:0]  model_cand = '0;
  bit          force_busy = 1'b0;
  bit          spur_valid = 1'b0;
  logic [7:0]  spur_cand  = '0;

  bit          busy_m  = 1'b0;
  bit          valid_m = 1'b0;
  logic [7:0]  cand_m  = '0;
  bit          sup_cur = 1'b0;
  int          rem     = 0;
  int          cyc     = 0;
  int          en_count    = 0;
  int          en_busy_err = 0;
  int          en_cyc      = 0;
  logic [23:0] cap_central = '0;
  logic [11:0] cap_radius  = '0;
  logic [1:0]  cap_mode    = '0;

  logic [TAG_W-1:0] log_tag  [$];
  logic [7:0]       log_cand [$];
  bit               log_to   [$];

  assign busy      = busy_m | force_busy;
  assign valid     = valid_m | spur_valid;
  assign candidate = spur_valid ? spur_cand : cand_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      busy_m  = 1'b0;
      valid_m = 1'b0;
      rem     = 0;
    end else begin
      if (hif.res_valid && hif.res_ready) begin
        log_tag.push_back(hif.res_tag);
        log_cand.push_back(hif.res_candidate);
        log_to.push_back(hif.res_timeout);
      end
      if (en && busy) en_busy_err++;
      if (valid_m) begin
        valid_m = 1'b0;
        busy_m  = 1'b0;
      end
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          if (sup_cur) busy_m = 1'b0;
          else         valid_m = 1'b1;
        end
      end
      if (en) begin
        en_count++;
        en_cyc      = cyc;
        cap_central = central;
        cap_radius  = radius;
        cap_mode    = mode;
        rem         = model_lat;
        sup_cur     = model_sup;
        cand_m      = model_echo ? central[7:0] : model_cand;
        busy_m      = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] m, input logic [TAG_W-1:0] t);
    bit ok = 1'b0;
    hif.cmd_central = c;
    hif.cmd_radius  = r;
    hif.cmd_mode    = m;
    hif.cmd_tag     = t;
    hif.cmd_valid   = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      ok = hif.cmd_ready;
      @(negedge clk);
    end
    hif.cmd_valid = 1'b0;
    if (!ok) check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_en(input int base);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (en_count > base) seen = 1'b1;
      else                 @(negedge clk);
    end
    check("en_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_res(output int rc);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (hif.res_valid) seen = 1'b1;
      else               @(negedge clk);
    end
    rc = cyc;
    check("res_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_log(input int n);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (log_tag.size() >= n) done = 1'b1;
      else                     @(negedge clk);
    end
    check("results_logged", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  en0, e1, e2, r, lb;
    bit  stable, quiet;

    hif.cmd_valid   = 1'b0;
    hif.cmd_central = '0;
    hif.cmd_radius  = '0;
    hif.cmd_mode    = '0;
    hif.cmd_tag     = '0;
    hif.res_ready   = 1'b0;

    // Reset state
    step(3);
    check("rst_en",         32'(en), 32'd0);
    check("rst_res_valid",  32'(hif.res_valid), 32'd0);
    check("rst_level",      32'(fifo_level), 32'd0);
    check("rst_res_cand",   32'(hif.res_candidate), 32'd0);
    check("rst_res_tag",    32'(hif.res_tag), 32'd0);
    check("rst_res_to",     32'(hif.res_timeout), 32'd0);
    check("rst_central",    32'(central), 32'd0);
    rst = 1'b0;
    step(2);

    // Single command, SET answers 66 cycles after en
    model_lat  = 66;
    model_cand = 8'd29;
    en0 = en_count;
    push_cmd(24'h440000, 12'h300, MODE_SINGLE, 4'd3);
    wait_en(en0);
    e1 = en_cyc;
    model_lat  = 3;
    model_cand = 8'h5A;
    check("t1_central", 32'(cap_central), 32'h440000);
    check("t1_radius",  32'(cap_radius), 32'h300);
    check("t1_mode",    32'(cap_mode), 32'(MODE_SINGLE));
    wait_res(r);
    check("t1_latency", 32'(r - e1), 32'd67);
    check("t1_cand",    32'(hif.res_candidate), 32'd29);
    check("t1_tag",     32'(hif.res_tag), 32'd3);
    check("t1_to",      32'(hif.res_timeout), 32'd0);
    check("t1_en_once", 32'(en_count - en0), 32'd1);

    // Result backpressure for 20 cycles while four more commands queue up
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        hif.cmd_central = 24'(i);
        hif.cmd_radius  = 12'h222;
        hif.cmd_mode    = MODE_AND;
        hif.cmd_tag     = TAG_W'(10 + i);
        hif.cmd_valid   = 1'b1;
      end else begin
        hif.cmd_valid = 1'b0;
      end
      stable &= (hif.res_valid === 1'b1) && (hif.res_candidate === 8'd29) &&
                (hif.res_tag === 4'd3) && (hif.res_timeout === 1'b0);
      @(negedge clk);
    end
    hif.cmd_valid = 1'b0;
    check("bp_res_stable", 32'(stable), 32'd1);
    check("bp_level_full", 32'(fifo_level), 32'd4);
    check("bp_cmd_ready",  32'(hif.cmd_ready), 32'd0);
    check("bp_no_2nd_en",  32'(en_count - en0), 32'd1);
    hif.res_ready = 1'b1;
    wait_log(5);
    check("bp_first_tag",  32'(log_tag[0]), 32'd3);
    check("bp_first_cand", 32'(log_cand[0]), 32'd29);
    check("bp_last_tag",   32'(log_tag[4]), 32'd13);
    check("bp_last_cand",  32'(log_cand[4]), 32'h5A);
    step(4);

    // Back-to-back: fill while the engine reports busy, then drain
    model_echo = 1'b1;
    force_busy = 1'b1;
    en0 = en_count;
    lb  = log_tag.size();
    for (int t = 0; t < 4; t++)
      push_cmd(24'(t * 16 + 5), 12'h111, MODE_XOR, TAG_W'(t));
    check("b2b_level4",    32'(fifo_level), 32'd4);
    check("b2b_ready_low", 32'(hif.cmd_ready), 32'd0);
    hif.cmd_central = 24'(4 * 16 + 5);
    hif.cmd_tag     = 4'd4;
    hif.cmd_valid   = 1'b1;
    step(3);
    check("b2b_full_hold",  32'({hif.cmd_ready, fifo_level}), 32'({1'b0, 3'd4}));
    check("b2b_no_en_busy", 32'(en_count - en0), 32'd0);
    force_busy = 1'b0;
    push_cmd(24'(4 * 16 + 5), 12'h111, MODE_XOR, 4'd4);
    wait_log(lb + 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b2b_tag%0d", k),  32'(log_tag[lb + k]), 32'(k));
      check($sformatf("b2b_cand%0d", k), 32'(log_cand[lb + k]), 32'(k * 16 + 5));
      check($sformatf("b2b_to%0d", k),   32'(log_to[lb + k]), 32'd0);
    end
    check("b2b_en_count",  32'(en_count - en0), 32'd5);
    check("b2b_en_busy",   32'(en_busy_err), 32'd0);
    model_echo = 1'b0;
    step(4);

    // Timeout: engine stays busy 150 cycles and never strobes valid
    hif.res_ready = 1'b0;
    model_sup = 1'b1;
    model_lat = 150;
    en0 = en_count;
    push_cmd(24'h123456, 12'h777, MODE_TWO, 4'd6);
    wait_en(en0);
    e1 = en_cyc;
    wait_res(r);
    check("to_latency", 32'(r - e1), 32'(TIMEOUT + 1));
    check("to_flag",    32'(hif.res_timeout), 32'd1);
    check("to_cand",    32'(hif.res_candidate), 32'd0);
    check("to_tag",     32'(hif.res_tag), 32'd6);

    // Valid lands exactly on the timeout cycle: valid wins
    model_sup  = 1'b0;
    model_lat  = TIMEOUT;
    model_cand = 8'd7;
    hif.res_ready = 1'b1;
    push_cmd(24'h000000, 12'h000, MODE_AND, 4'd7);
    wait_en(en0 + 1);
    e2 = en_cyc;
    check("to_waits_busy", 32'(e2 - e1), 32'd151);
    wait_res(r);
    check("edge_latency", 32'(r - e2), 32'(TIMEOUT + 1));
    check("edge_cand",    32'(hif.res_candidate), 32'd7);
    check("edge_to",      32'(hif.res_timeout), 32'd0);
    check("edge_tag",     32'(hif.res_tag), 32'd7);
    check("edge_en_busy", 32'(en_busy_err), 32'd0);
    step(4);

    // Asynchronous reset 30 cycles into WAIT
    model_lat  = 66;
    model_cand = 8'h2A;
    en0 = en_count;
    push_cmd(24'hABCDEF, 12'h123, MODE_AND, 4'd8);
    wait_en(en0);
    e1 = en_cyc;
    push_cmd(24'h000001, 12'h001, MODE_SINGLE, 4'd2);
    for (int i = 0; i < 200 && cyc < e1 + 31; i++) step(1);
    check("mid_level_pre", 32'(fifo_level), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_en",    32'(en), 32'd0);
    check("mid_rst_res",   32'(hif.res_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_cent",  32'(central), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    en0 = en_count;
    push_cmd(24'h440000, 12'h300, MODE_AND, 4'd9);
    wait_en(en0);
    check("post_rst_mode", 32'(cap_mode), 32'(MODE_AND));
    wait_res(r);
    check("post_rst_tag",  32'(hif.res_tag), 32'd9);
    check("post_rst_cand", 32'(hif.res_candidate), 32'h2A);
    check("post_rst_to",   32'(hif.res_timeout), 32'd0);
    step(3);

    // Spurious valid while IDLE
    en0 = en_count;
    spur_cand  = 8'd5;
    spur_valid = 1'b1;
    step(1);
    spur_valid = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      quiet &= (hif.res_valid === 1'b0);
      step(1);
    end
    check("spur_no_res", 32'(quiet), 32'd1);
    check("spur_level",  32'(fifo_level), 32'd0);
    check("spur_no_en",  32'(en_count - en0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
